// File: rtl/i2c_master_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_pkg
// Brief    : Shared types and width defaults for the I2C master arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_ADDR_WIDTH  = DEF_DATA_WIDTH - 1;
    localparam int DEF_PRESC_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        RELEASE   = 2'd3
    } arb_state_t;

    // Index width for a requester vector; never narrower than one bit.
    function automatic int req_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_master_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : i2c_master_arbiter_if
// Brief    : Command/status bundle between the arbiter and one i2c_master.
// Revision : 1.0 - initial release
// ============================================================================
interface i2c_master_arbiter_if #(
    parameter int PRESC_WIDTH = 16,
    parameter int DATA_WIDTH  = 8
);

    logic                    m_en_o;
    logic [PRESC_WIDTH-1:0]  m_prescale_o;
    logic [DATA_WIDTH-1:0]   m_data_o;
    logic [DATA_WIDTH-2:0]   m_slave_addr_o;
    logic                    m_dir_o;
    logic                    m_busy_i;

    // Arbiter side drives the command fields and watches busy.
    modport master (
        output m_en_o,
        output m_prescale_o,
        output m_data_o,
        output m_slave_addr_o,
        output m_dir_o,
        input  m_busy_i
    );

    modport slave (
        input  m_en_o,
        input  m_prescale_o,
        input  m_data_o,
        input  m_slave_addr_o,
        input  m_dir_o,
        output m_busy_i
    );

endinterface
`default_nettype wire

// File: rtl/i2c_master_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker: first request at/after ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import i2c_pkg::*;
#(
    parameter int REQ_NUM   = 4,
    parameter int IDX_WIDTH = req_idx_width(REQ_NUM)
) (
    input  logic [REQ_NUM-1:0]   req_i,
    input  logic [IDX_WIDTH-1:0] ptr_i,
    output logic                 valid_o,
    output logic [IDX_WIDTH-1:0] idx_o,
    output logic [REQ_NUM-1:0]   gnt_o
);

    localparam logic [IDX_WIDTH:0] c_req_num = (IDX_WIDTH+1)'(REQ_NUM);

    logic [2*REQ_NUM-1:0] w_req_dbl;
    logic [REQ_NUM-1:0]   w_rot;
    logic [IDX_WIDTH-1:0] w_off;
    logic [IDX_WIDTH:0]   w_sum;

    // Doubling the vector turns the wrap-around search into a plain slice.
    assign w_req_dbl = {req_i, req_i};
    assign w_rot     = w_req_dbl[ptr_i +: REQ_NUM];
    assign valid_o   = |req_i;

    always_comb begin
        w_off = '0;
        for (int j = REQ_NUM - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = IDX_WIDTH'(j);
            end
        end
    end

    assign w_sum = {1'b0, ptr_i} + {1'b0, w_off};
    assign idx_o = (w_sum >= c_req_num) ? IDX_WIDTH'(w_sum - c_req_num)
                                        : w_sum[IDX_WIDTH-1:0];

    always_comb begin
        gnt_o = '0;
        if (valid_o) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2c_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : i2c_master_arbiter
// Brief    : Round-robin sharing of one i2c_master among REQ_NUM requesters.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_master_arbiter
    import i2c_pkg::*;
#(
    parameter int REQ_NUM       = 4,
    parameter int PRESC_WIDTH   = DEF_PRESC_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int TIMEOUT_WIDTH = 20
) (
    input  logic                             clk_i,
    input  logic                             a_rst_n_i,
    input  logic [PRESC_WIDTH-1:0]           prescale_i,
    input  logic [TIMEOUT_WIDTH-1:0]         timeout_i,
    input  logic [REQ_NUM-1:0]               req_i,
    input  logic [REQ_NUM*(DATA_WIDTH-1)-1:0] req_addr_i,
    input  logic [REQ_NUM*DATA_WIDTH-1:0]    req_data_i,
    input  logic [REQ_NUM-1:0]               req_dir_i,
    output logic [REQ_NUM-1:0]               gnt_o,
    output logic [REQ_NUM-1:0]               done_o,
    output logic [REQ_NUM-1:0]               err_o,
    output logic                             busy_o,
    i2c_master_arbiter_if.master             m_bus
);

    localparam int ADDR_WIDTH    = DATA_WIDTH - 1;
    localparam int REQ_IDX_WIDTH = req_idx_width(REQ_NUM);
    localparam logic [REQ_IDX_WIDTH-1:0] c_last_idx = REQ_IDX_WIDTH'(REQ_NUM - 1);

    arb_state_t                r_state, w_next_state;
    logic [REQ_IDX_WIDTH-1:0]  r_ptr, w_ptr_nxt;
    logic [REQ_IDX_WIDTH-1:0]  r_idx, w_idx_nxt;
    logic [TIMEOUT_WIDTH-1:0]  r_wdog, w_wdog_nxt;
    logic [REQ_NUM-1:0]        r_gnt, w_gnt_nxt;
    logic [REQ_NUM-1:0]        r_done, w_done_nxt;
    logic [REQ_NUM-1:0]        r_err, w_err_nxt;
    logic                      r_busy, w_busy_nxt;
    logic                      r_m_en, w_m_en_nxt;
    logic                      r_m_dir, w_m_dir_nxt;
    logic [PRESC_WIDTH-1:0]    r_m_prescale, w_m_prescale_nxt;
    logic [DATA_WIDTH-1:0]     r_m_data, w_m_data_nxt;
    logic [ADDR_WIDTH-1:0]     r_m_addr, w_m_addr_nxt;

    logic                      w_pick_valid;
    logic [REQ_IDX_WIDTH-1:0]  w_pick_idx;
    logic [REQ_NUM-1:0]        w_pick_gnt;
    logic                      w_active;
    logic                      w_timeout_hit;

    logic [ADDR_WIDTH-1:0]     w_addr_arr [REQ_NUM];
    logic [DATA_WIDTH-1:0]     w_data_arr [REQ_NUM];

    for (genvar k = 0; k < REQ_NUM; k++) begin : g_unpack
        assign w_addr_arr[k] = req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_data_arr[k] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_pick #(
        .REQ_NUM   (REQ_NUM),
        .IDX_WIDTH (REQ_IDX_WIDTH)
    ) u_rr_pick (
        .req_i   (req_i),
        .ptr_i   (r_ptr),
        .valid_o (w_pick_valid),
        .idx_o   (w_pick_idx),
        .gnt_o   (w_pick_gnt)
    );

    assign w_active      = (r_state == LAUNCH) || (r_state == WAIT_DONE);
    // A zero limit disables the watchdog; the limit wins over a busy edge.
    assign w_timeout_hit = w_active && (timeout_i != '0) &&
                           (r_wdog == timeout_i - TIMEOUT_WIDTH'(1));

    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_idx        <= '0;
            r_wdog       <= '0;
            r_gnt        <= '0;
            r_done       <= '0;
            r_err        <= '0;
            r_busy       <= 1'b0;
            r_m_en       <= 1'b0;
            r_m_dir      <= 1'b0;
            r_m_prescale <= '0;
            r_m_data     <= '0;
            r_m_addr     <= '0;
        end else begin
            r_state      <= w_next_state;
            r_ptr        <= w_ptr_nxt;
            r_idx        <= w_idx_nxt;
            r_wdog       <= w_wdog_nxt;
            r_gnt        <= w_gnt_nxt;
            r_done       <= w_done_nxt;
            r_err        <= w_err_nxt;
            r_busy       <= w_busy_nxt;
            r_m_en       <= w_m_en_nxt;
            r_m_dir      <= w_m_dir_nxt;
            r_m_prescale <= w_m_prescale_nxt;
            r_m_data     <= w_m_data_nxt;
            r_m_addr     <= w_m_addr_nxt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_next_state = LAUNCH;
                end
            end
            LAUNCH: begin
                if (w_timeout_hit) begin
                    w_next_state = RELEASE;
                end else if (m_bus.m_busy_i) begin
                    w_next_state = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (w_timeout_hit || !m_bus.m_busy_i) begin
                    w_next_state = RELEASE;
                end
            end
            RELEASE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        w_ptr_nxt        = r_ptr;
        w_idx_nxt        = r_idx;
        w_wdog_nxt       = r_wdog;
        w_gnt_nxt        = r_gnt;
        w_done_nxt       = '0;
        w_err_nxt        = '0;
        w_m_en_nxt       = r_m_en;
        w_m_dir_nxt      = r_m_dir;
        w_m_prescale_nxt = r_m_prescale;
        w_m_data_nxt     = r_m_data;
        w_m_addr_nxt     = r_m_addr;
        w_busy_nxt       = (w_next_state != IDLE);
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_idx_nxt        = w_pick_idx;
                    w_gnt_nxt        = w_pick_gnt;
                    w_wdog_nxt       = '0;
                    w_m_en_nxt       = 1'b1;
                    w_m_dir_nxt      = req_dir_i[w_pick_idx];
                    w_m_prescale_nxt = prescale_i;
                    w_m_data_nxt     = w_data_arr[w_pick_idx];
                    w_m_addr_nxt     = w_addr_arr[w_pick_idx];
                end
            end
            LAUNCH, WAIT_DONE: begin
                w_wdog_nxt = r_wdog + TIMEOUT_WIDTH'(1);
                if (w_next_state == RELEASE) begin
                    w_gnt_nxt  = '0;
                    w_m_en_nxt = 1'b0;
                    if (w_timeout_hit) begin
                        w_err_nxt = r_gnt;
                    end else begin
                        w_done_nxt = r_gnt;
                    end
                    w_ptr_nxt = (r_idx == c_last_idx) ? '0 : r_idx + REQ_IDX_WIDTH'(1);
                end
            end
            default: begin
            end
        endcase
    end

    assign gnt_o                = r_gnt;
    assign done_o               = r_done;
    assign err_o                = r_err;
    assign busy_o               = r_busy;
    assign m_bus.m_en_o         = r_m_en;
    assign m_bus.m_prescale_o   = r_m_prescale;
    assign m_bus.m_data_o       = r_m_data;
    assign m_bus.m_slave_addr_o = r_m_addr;
    assign m_bus.m_dir_o        = r_m_dir;

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_master_arbiter
// Brief    : Directed scoreboard bench for the round-robin I2C master arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_master_arbiter;

    typedef struct {
        int          idx;
        logic [6:0]  addr;
        logic [7:0]  data;
        logic        dir;
        logic [15:0] presc;
    } exp_t;

    logic        clk = 1'b0;
    logic        a_rst_n;
    logic [15:0] prescale;
    logic [19:0] timeout;
    logic [3:0]  req;
    logic [27:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  req_dir;
    logic [3:0]  gnt, done, err;
    logic        busy;

    logic [6:0]  addr_tab [4];
    logic [7:0]  data_tab [4];
    logic        dir_tab  [4];
    exp_t        sb [$];

    int n_assert = 0;
    int n_fail   = 0;

    i2c_master_arbiter_if #(.PRESC_WIDTH(16), .DATA_WIDTH(8)) u_bus ();

    i2c_master_arbiter #(
        .REQ_NUM       (4),
        .PRESC_WIDTH   (16),
        .DATA_WIDTH    (8),
        .TIMEOUT_WIDTH (20)
    ) u_dut (
        .clk_i      (clk),
        .a_rst_n_i  (a_rst_n),
        .prescale_i (prescale),
        .timeout_i  (timeout),
        .req_i      (req),
        .req_addr_i (req_addr),
        .req_data_i (req_data),
        .req_dir_i  (req_dir),
        .gnt_o      (gnt),
        .done_o     (done),
        .err_o      (err),
        .busy_o     (busy),
        .m_bus      (u_bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic drive_bus();
        for (int k = 0; k < 4; k++) begin
            req_addr[k*7 +: 7] = addr_tab[k];
            req_data[k*8 +: 8] = data_tab[k];
            req_dir[k]         = dir_tab[k];
        end
    endtask

    task automatic push_exp(input int k);
        exp_t e;
        e.idx   = k;
        e.addr  = addr_tab[k];
        e.data  = data_tab[k];
        e.dir   = dir_tab[k];
        e.presc = prescale;
        sb.push_back(e);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_gnt"},   gnt, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_err"},   err, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_m_en"},  u_bus.m_en_o, 0);
        check({tag, "_presc"}, u_bus.m_prescale_o, 0);
        check({tag, "_data"},  u_bus.m_data_o, 0);
        check({tag, "_addr"},  u_bus.m_slave_addr_o, 0);
        check({tag, "_dir"},   u_bus.m_dir_o, 0);
    endtask

    // One arbitrated transaction: grant, master busy model, completion pulse.
    task automatic serve(input int busy_delay, input int busy_len, input bit exp_err,
                         input bit busy_level, input int exp_lat,
                         input logic [3:0] drop_mask, input bit mutate);
        exp_t       e;
        logic [3:0] oh;
        int         n;
        bit         seen;
        n = 0;
        while (gnt == 4'b0000 && n < 8) begin
            tick();
            n++;
        end
        check("grant_latency", n, 1);
        check("sb_nonempty", (sb.size() != 0), 1);
        if (sb.size() == 0) return;
        e  = sb.pop_front();
        oh = 4'b0001 << e.idx;
        check("gnt", gnt, oh);
        check("m_en", u_bus.m_en_o, 1);
        check("m_addr", u_bus.m_slave_addr_o, e.addr);
        check("m_data", u_bus.m_data_o, e.data);
        check("m_dir", u_bus.m_dir_o, e.dir);
        check("m_presc", u_bus.m_prescale_o, e.presc);
        check("busy_o_grant", busy, 1);
        seen = 1'b0;
        if (!exp_err) begin
            repeat (busy_delay) begin
                tick();
                seen |= |(done | err);
            end
            u_bus.m_busy_i = 1'b1;
            if (mutate) begin
                req = req & ~oh;
                data_tab[e.idx] = ~e.data;
                addr_tab[e.idx] = ~e.addr;
                drive_bus();
            end
            repeat (busy_len) begin
                tick();
                seen |= |(done | err);
            end
            check("m_data_hold", u_bus.m_data_o, e.data);
            check("m_addr_hold", u_bus.m_slave_addr_o, e.addr);
            check("gnt_hold", gnt, oh);
            u_bus.m_busy_i = 1'b0;
            tick();
            check("no_early_pulse", seen, 0);
            check("done", done, oh);
            check("err_none", err, 0);
        end else begin
            u_bus.m_busy_i = busy_level;
            n = 0;
            while ((done | err) == 4'b0000 && n < exp_lat + 4) begin
                tick();
                n++;
            end
            u_bus.m_busy_i = 1'b0;
            check("timeout_lat", n, exp_lat);
            check("err", err, oh);
            check("done_none", done, 0);
        end
        check("busy_o_release", busy, 1);
        check("m_en_release", u_bus.m_en_o, 0);
        check("gnt_release", gnt, 0);
        req = req & ~drop_mask;
        tick();
        check("done_clear", done, 0);
        check("err_clear", err, 0);
        check("busy_o_idle", busy, 0);
    endtask

    initial begin
        int n;
        a_rst_n  = 1'b0;
        prescale = 16'd250;
        timeout  = 20'd1000;
        req      = 4'b0000;
        u_bus.m_busy_i = 1'b0;
        addr_tab = '{7'h10, 7'h20, 7'h50, 7'h3A};
        data_tab = '{8'h11, 8'h22, 8'hA5, 8'h44};
        dir_tab  = '{1'b0, 1'b1, 1'b1, 1'b0};
        drive_bus();
        #2;
        check_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        a_rst_n = 1'b1;
        tick();

        // Single request on requester 2
        push_exp(2);
        req = 4'b0100;
        serve(2, 40, 1'b0, 1'b0, 0, 4'b0100, 1'b0);

        // Fresh pointer, then all requesters held
        a_rst_n = 1'b0;
        tick();
        a_rst_n = 1'b1;
        req = 4'b1111;
        push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0); push_exp(1);
        for (int i = 0; i < 6; i++) begin
            serve(1, 3, 1'b0, 1'b0, 0, (i == 5) ? 4'b1111 : 4'b0000, 1'b0);
        end

        // Watchdog expiry with busy stuck low
        timeout = 20'd16;
        push_exp(1);
        req = 4'b0010;
        serve(0, 0, 1'b1, 1'b0, 16, 4'b0010, 1'b0);

        // Normal service afterwards, pointer continues from 2
        timeout = 20'd1000;
        push_exp(3);
        push_exp(0);
        req = 4'b1001;
        serve(1, 4, 1'b0, 1'b0, 0, 4'b1000, 1'b0);
        serve(1, 4, 1'b0, 1'b0, 0, 4'b0001, 1'b0);

        // Timeout coincident with busy rising: error wins
        timeout = 20'd1;
        push_exp(1);
        req = 4'b0010;
        serve(0, 0, 1'b1, 1'b1, 1, 4'b0010, 1'b0);

        // Watchdog disabled, long busy
        timeout  = 20'd0;
        prescale = 16'h1234;
        push_exp(2);
        req = 4'b0100;
        serve(2, 5000, 1'b0, 1'b0, 0, 4'b0100, 1'b0);

        // Reset in WAIT_DONE, between edges
        timeout = 20'd1000;
        req = 4'b1000;
        n = 0;
        while (gnt == 4'b0000 && n < 8) begin
            tick();
            n++;
        end
        check("rst_grant", gnt, 4'b1000);
        tick();
        u_bus.m_busy_i = 1'b1;
        repeat (3) tick();
        check("rst_busy_o", busy, 1);
        #3;
        a_rst_n = 1'b0;
        #1;
        check_zero("rst_async");
        u_bus.m_busy_i = 1'b0;
        @(posedge clk);
        #1;
        check_zero("rst_held");
        a_rst_n = 1'b1;
        push_exp(3);
        serve(2, 6, 1'b0, 1'b0, 0, 4'b1000, 1'b0);

        // Inputs change and request drops mid-transaction
        data_tab[2] = 8'hC3;
        drive_bus();
        push_exp(2);
        req = 4'b0100;
        serve(2, 10, 1'b0, 1'b0, 0, 4'b0000, 1'b1);
        tick();
        tick();
        check("no_regrant", gnt, 0);
        check("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "bench time limit reached");
    end

endmodule
`default_nettype wire

// File: doc/i2c_master_arbiter.md
Name: i2c_master_arbiter

Overview:
- Shares one i2c_master instance between REQ_NUM requesters using a round-robin order.
- Latches the winning requester's address, data and direction, then drives the master's en/prescale/data/addr/dir inputs.
- Holds en for the whole transaction, detects completion from the master's busy flag, and returns a per-requester done or timeout-error pulse.
- Sits between the system-side requesters (sensor/config FSMs) and i2c_master.

Parameters:
REQ_NUM, 4, number of requesters (2..8)
PRESC_WIDTH, 16, prescaler width, matches i2c_master
DATA_WIDTH, 8, I2C byte width; ADDR_WIDTH = DATA_WIDTH-1 (localparam)
TIMEOUT_WIDTH, 20, watchdog counter width

Ports:
clk_i  in  1  clock
a_rst_n_i  in  1  reset, asynchronous assert, active-low
prescale_i  in  PRESC_WIDTH  SCL prescale, sampled at grant
timeout_i  in  TIMEOUT_WIDTH  watchdog limit in clk cycles; 0 = disabled
req_i  in  REQ_NUM  request, level, held until done/err
req_addr_i  in  REQ_NUM*ADDR_WIDTH  flat slave addresses, requester k at [k*ADDR_WIDTH +: ADDR_WIDTH]
req_data_i  in  REQ_NUM*DATA_WIDTH  flat write bytes
req_dir_i  in  REQ_NUM  direction bit per requester
gnt_o  out  REQ_NUM  one-hot grant, high for the whole transaction
done_o  out  REQ_NUM  one-cycle completion pulse
err_o  out  REQ_NUM  one-cycle timeout pulse
busy_o  out  1  arbiter not in IDLE
m_en_o  out  1  to i2c_master en_i
m_prescale_o  out  PRESC_WIDTH  to prescale_i
m_data_o  out  DATA_WIDTH  to data_i
m_slave_addr_o  out  ADDR_WIDTH  to slave_addr_i
m_dir_o  out  1  to dir_i
m_busy_i  in  1  master transaction in progress (START..STOP)

Behaviour:
- All outputs are registered. On reset assertion, with no clock needed: state=IDLE, all outputs 0, rr pointer=0, watchdog=0.
- States: IDLE, LAUNCH, WAIT_DONE, RELEASE.
- IDLE:
  - If any req_i is high, pick the first requester at or after the pointer, searching k = ptr, ptr+1, ... mod REQ_NUM.
  - Latch that requester's addr/data/dir and prescale_i into the m_* registers.
  - Set gnt_o one-hot, m_en_o=1, watchdog=0, go to LAUNCH.
  - m_en_o rises exactly 1 clk after req_i is sampled.
- LAUNCH:
  - m_en_o=1; watchdog increments.
  - m_busy_i=1 -> WAIT_DONE.
- WAIT_DONE:
  - m_en_o=1; watchdog increments.
  - m_busy_i=0 -> RELEASE with success.
- Watchdog:
  - In LAUNCH or WAIT_DONE, if timeout_i!=0 and watchdog==timeout_i-1 -> RELEASE with error.
  - Timeout has priority over a simultaneous busy edge.
- RELEASE (1 cycle):
  - m_en_o=0, gnt_o=0.
  - done_o[k]=1 or err_o[k]=1 (never both).
  - ptr <= (k+1) mod REQ_NUM.
  - Next state IDLE; a new grant can start the following cycle.
- m_* data outputs stay stable from grant until the next grant; input changes mid-transaction are ignored.
- req_i dropped mid-transaction: the transaction still completes and done_o/err_o still pulse for that requester.
- A requester holding req_i after done is eligible again, but only after the other pending requesters have been served.
- Pointer wrap: ptr=REQ_NUM-1 -> next search starts at REQ_NUM-1, then wraps to 0.
- Reset mid-transaction: immediate return to IDLE, no done/err pulse. A pending request is re-arbitrated from ptr=0 after reset release.
- busy_o = (state != IDLE).

Decomposition:
- Package i2c_pkg:
  - arb_state_t enum (IDLE, LAUNCH, WAIT_DONE, RELEASE)
  - DATA_WIDTH / ADDR_WIDTH / PRESC_WIDTH defaults
  - REQ_IDX_WIDTH = $clog2(REQ_NUM) helper
- Sub-module rr_pick: combinational; inputs req vector and pointer; outputs valid, winner index and one-hot grant. Reusable by other arbiters.

Test Plan:
1. Single request: REQ_NUM=4, req_i=4'b0100, addr[2]=7'h50, data[2]=8'hA5, dir=1, timeout_i=1000; master model raises m_busy_i 2 clk after m_en_o and holds it 40 clk.
   Required: m_en_o high 1 clk after req, gnt_o=4'b0100, m_slave_addr_o=7'h50, m_data_o=8'hA5; done_o=4'b0100 for one cycle, 1 clk after busy falls; busy_o low 1 clk later.
2. Fairness: req_i=4'b1111 held continuously. Required: grant order 0,1,2,3,0,1 and no requester starves.
3. Timeout: timeout_i=16, m_busy_i stuck 0. Required: err_o[k] pulses after 16 cycles in LAUNCH; done_o stays 0; next request is served normally.
4. Watchdog disabled: timeout_i=0, busy held 5000 clk. Required: no err_o, a single done_o pulse.
5. Reset mid-transaction: assert a_rst_n_i low in WAIT_DONE between clock edges. Required: all outputs 0 before the next edge; after release, held req_i=4'b1000 is re-granted with ptr search from 0.
6. Input stability: drop req_i and change req_data_i mid-transaction. Required: m_data_o unchanged and done_o still pulses for the original requester.
